// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: field widths and the hex glyph table.
// Segment order is seg[6]=a ... seg[0]=g, active-high before any output polarity inversion.
package seg7_pkg;
   localparam int SEG_W    = 7;
   localparam int NIBBLE_W = 4;

   localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
   };
endpackage

// File: rtl/seg7_hex_decode.sv
// Hex nibble to 7-segment glyph lookup.
// Purely combinational, zero latency, no flow control.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [NIBBLE_W-1:0] hex,
   output logic [SEG_W-1:0]    seg
);
   assign seg = SEG_TABLE[hex];
endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scanner with a shadow register committed only at frame boundaries.
// Outputs are combinational from registered state; SEG7_LEADING_ZERO_BLANK_EN enables leading-zero blanking.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 1000,
   parameter int ACTIVE_LOW  = 0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           load,
   input  logic [NIBBLE_W*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]          dp_in,
   output logic [SEG_W-1:0]               seg,
   output logic                           dp,
   output logic [NUM_DIGITS-1:0]          an,
   output logic                           pending,
   output logic                           frame_done
);
   localparam int VAL_W = NIBBLE_W * NUM_DIGITS;
   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [VAL_W-1:0]      disp_val_q, disp_val_d;
   logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
   logic [VAL_W-1:0]      shadow_val_q, shadow_val_d;
   logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
   logic                  pending_q, pending_d;
   logic                  frame_done_q, frame_done_d;
   logic                  tick, commit;

   always_comb begin
      tick         = (cnt_q == CNT_LAST);
      commit       = tick && (idx_q == IDX_LAST);
      cnt_d        = tick ? '0 : cnt_q + CNT_W'(1);
      idx_d        = idx_q;
      if (tick) begin
         idx_d = commit ? '0 : idx_q + IDX_W'(1);
      end
      disp_val_d   = disp_val_q;
      disp_dp_d    = disp_dp_q;
      shadow_val_d = shadow_val_q;
      shadow_dp_d  = shadow_dp_q;
      pending_d    = pending_q;
      frame_done_d = commit;
      // A load landing on the commit edge bypasses the shadow, so any older shadow is dropped.
      if (load && commit) begin
         disp_val_d = value;
         disp_dp_d  = dp_in;
         pending_d  = 1'b0;
      end else if (load) begin
         shadow_val_d = value;
         shadow_dp_d  = dp_in;
         pending_d    = 1'b1;
      end else if (commit && pending_q) begin
         disp_val_d = shadow_val_q;
         disp_dp_d  = shadow_dp_q;
         pending_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         disp_val_q   <= '0;
         disp_dp_q    <= '0;
         shadow_val_q <= '0;
         shadow_dp_q  <= '0;
         pending_q    <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         disp_val_q   <= disp_val_d;
         disp_dp_q    <= disp_dp_d;
         shadow_val_q <= shadow_val_d;
         shadow_dp_q  <= shadow_dp_d;
         pending_q    <= pending_d;
         frame_done_q <= frame_done_d;
      end
   end

   logic [NIBBLE_W-1:0]   nib;
   logic                  dp_raw;
   logic [NUM_DIGITS-1:0] an_raw;
   logic [SEG_W-1:0]      seg_dec, seg_raw;

   always_comb begin
      nib    = '0;
      dp_raw = 1'b0;
      an_raw = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            nib       = disp_val_q[i*NIBBLE_W +: NIBBLE_W];
            dp_raw    = disp_dp_q[i];
            an_raw[i] = 1'b1;
         end
      end
   end

   seg7_hex_decode u_hex_decode (
      .hex (nib),
      .seg (seg_dec)
   );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   logic zero_run, blank_cur;

   // Walk from the most significant digit down; digit 0 is never considered for blanking.
   always_comb begin
      zero_run  = 1'b1;
      blank_cur = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_run = zero_run && (disp_val_q[i*NIBBLE_W +: NIBBLE_W] == '0);
         if (idx_q == IDX_W'(i)) begin
            blank_cur = zero_run;
         end
      end
   end

   assign seg_raw = blank_cur ? '0 : seg_dec;
`else
   assign seg_raw = seg_dec;
`endif

   assign seg        = (ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
   assign dp         = (ACTIVE_LOW != 0) ? ~dp_raw  : dp_raw;
   assign an         = (ACTIVE_LOW != 0) ? ~an_raw  : an_raw;
   assign pending    = pending_q;
   assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (4 digits, 4 cycles per digit); stimulus pushes the
// expected post-edge outputs into a scoreboard queue that a negedge monitor pops and checks.
module tb_seg7_scan_driver;
   localparam int ND = 4;
   localparam int RD = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        pending;
   logic        frame_done;

   always #5 clk = ~clk;

   seg7_scan_driver #(
      .NUM_DIGITS  (ND),
      .REFRESH_DIV (RD),
      .ACTIVE_LOW  (0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .value      (value),
      .dp_in      (dp_in),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .pending    (pending),
      .frame_done (frame_done)
   );

   typedef struct packed {
      logic [15:0] t;
      logic [3:0]  an;
      logic [6:0]  seg;
      logic        dp;
      logic        pend;
      logic        fd;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   // Bench-side view of what the display should hold after the next edge.
   int          t;
   logic [15:0] e_val;
   logic [3:0]  e_dp;
   logic        e_pend;

   logic [6:0] hex_tab [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
   };

   function automatic exp_t expect_now();
      exp_t       e;
      int         idx;
      logic [3:0] nib;
      idx    = (t / RD) % ND;
      nib    = e_val[4*idx +: 4];
      e.t    = 16'(t);
      e.an   = 4'(1 << idx);
      e.seg  = hex_tab[nib];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (idx != 0 && (e_val >> (4*idx)) == 16'h0000) e.seg = 7'h00;
`endif
      e.dp   = e_dp[idx];
      e.pend = e_pend;
      e.fd   = (t != 0) && (t % (RD*ND) == 0);
      return e;
   endfunction

   task automatic step(input logic r, input logic l, input logic [15:0] v, input logic [3:0] d);
      rst   = r;
      load  = l;
      value = v;
      dp_in = d;
      @(posedge clk);
      t = r ? 0 : t + 1;
      sb_q.push_back(expect_now());
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 16'($urandom), 4'($urandom));
   endtask

   task automatic chk(input string name, input logic [15:0] tt, input logic [6:0] act, input logic [6:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s t=%0d got=%h want=%h", name, tt, act, req);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         chk("an",         e.t, {3'b0, an},         {3'b0, e.an});
         chk("seg",        e.t, seg,                e.seg);
         chk("dp",         e.t, {6'b0, dp},         {6'b0, e.dp});
         chk("pending",    e.t, {6'b0, pending},    {6'b0, e.pend});
         chk("frame_done", e.t, {6'b0, frame_done}, {6'b0, e.fd});
      end
   end

   initial begin
      rst = 1'b1; load = 1'b0; value = '0; dp_in = '0;
      t = 0; e_val = '0; e_dp = '0; e_pend = 1'b0;

      // Reset, including a load that reset must override.
      step(1'b1, 1'b0, 16'h0000, 4'h0);
      step(1'b1, 1'b1, 16'h1234, 4'hF);
      step(1'b1, 1'b0, 16'h0000, 4'h0);

      idle(20);                                   // free-running scan, commit at t=16

      e_pend = 1'b1;
      step(1'b0, 1'b1, 16'h12AF, 4'b0100);        // t=21, held in shadow
      idle(10);                                   // t=31, display still blank
      e_val = 16'h12AF; e_dp = 4'b0100; e_pend = 1'b0;
      idle(1);                                    // t=32 commit
      idle(18);                                   // t=50

      e_pend = 1'b1;
      step(1'b0, 1'b1, 16'h1111, 4'b0001);        // t=51
      idle(2);
      step(1'b0, 1'b1, 16'h2222, 4'b1000);        // t=54, last load wins
      idle(9);                                    // t=63
      e_val = 16'h2222; e_dp = 4'b1000; e_pend = 1'b0;
      idle(1);                                    // t=64 commit
      idle(15);                                   // t=79

      e_val = 16'h9BCD; e_dp = 4'b0011;
      step(1'b0, 1'b1, 16'h9BCD, 4'b0011);        // t=80 load on commit edge
      idle(20);                                   // t=100

      e_pend = 1'b1;
      step(1'b0, 1'b1, 16'hE4E4, 4'b1111);        // t=101, later discarded
      idle(10);                                   // t=111
      e_val = 16'h5678; e_dp = 4'b0000; e_pend = 1'b0;
      step(1'b0, 1'b1, 16'h5678, 4'b0000);        // t=112 commit-edge load drops shadow
      idle(20);                                   // t=132, commit at 128 keeps 5678

      e_pend = 1'b1;
      step(1'b0, 1'b1, 16'h0050, 4'b0001);        // t=133
      idle(10);
      e_val = 16'h0050; e_dp = 4'b0001; e_pend = 1'b0;
      idle(1);                                    // t=144 commit
      idle(19);                                   // t=163

      e_pend = 1'b1;
      step(1'b0, 1'b1, 16'h04E0, 4'b0000);        // t=164
      idle(11);
      e_val = 16'h04E0; e_dp = 4'b0000; e_pend = 1'b0;
      idle(1);                                    // t=176 commit
      idle(21);                                   // t=197

      e_pend = 1'b1;
      step(1'b0, 1'b1, 16'h6666, 4'hF);           // t=198
      idle(3);
      e_val = 16'h0000; e_dp = 4'b0000; e_pend = 1'b0;
      step(1'b1, 1'b0, 16'h0000, 4'h0);           // reset discards pending
      idle(20);                                   // no commit of 6666 at t=16

      repeat (3) @(negedge clk);
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL drain got=%0d want=0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
